bitonic_unload_serializer: RTL and testbench

//   Sink end of the bitonic sorter output interface. Captures each sorted frame (2**LOG_INPUT

---
 rtl/bitonic_unload_serializer_pkg.sv | 26 ++
 rtl/bitonic_unload_serializer_frame_buf.sv | 45 ++++
 rtl/bitonic_unload_serializer.sv | 160 ++++++++++++++++
 tb/tb_bitonic_unload_serializer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_unload_serializer_pkg.sv
// Shared types and helpers for the bitonic sorter unload path (package bitonic_pkg).
package bitonic_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 4;
  localparam int unsigned LOG_INPUT_DEF  = 5;
  localparam int unsigned N              = 2 ** LOG_INPUT_DEF;
  localparam int unsigned FRAME_W        = DATA_WIDTH_DEF * N;

  // Upper bounds for the generic slicing helper; any legal configuration must fit inside.
  localparam int unsigned ELEM_W_MAX  = 32;
  localparam int unsigned FRAME_W_MAX = 2048;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  function automatic logic [ELEM_W_MAX-1:0] elem_sel(input logic [FRAME_W_MAX-1:0] frame,
                                                     input int unsigned k,
                                                     input int unsigned dw);
    logic [ELEM_W_MAX-1:0] mask;
    mask = (ELEM_W_MAX'(1'b1) << dw) - ELEM_W_MAX'(1'b1);
    return ELEM_W_MAX'(frame >> (k * dw)) & mask;
  endfunction

endpackage

// File: rtl/bitonic_unload_serializer_frame_buf.sv
// Single-frame holding register with a FULL flag; a load wins over a release in the same cycle.
module bitonic_frame_buf
  import bitonic_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = FRAME_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   release_i,
  input  logic [FRAME_WIDTH-1:0] data_i,
  output logic [FRAME_WIDTH-1:0] data_o,
  output logic                   full_o
);

  logic [FRAME_WIDTH-1:0] data_q, data_d;
  logic                   full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (release_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= {FRAME_WIDTH{1'b0}};
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/bitonic_unload_serializer.sv
// Ping-pong capture of sorted frames, serialized one element per valid/ready beat.
// Optional macro BITONIC_UNLOAD_REVERSE_EN emits each frame in descending order.
module bitonic_unload_serializer
  import bitonic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LOG_INPUT  = LOG_INPUT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]  in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [LOG_INPUT-1:0]                  out_index,
  output logic                                  out_last,
  output logic                                  overflow
);

  localparam int unsigned NUM_ELEM    = 2 ** LOG_INPUT;
  localparam int unsigned FRAME_WIDTH = DATA_WIDTH * NUM_ELEM;
  localparam logic [LOG_INPUT-1:0] LAST_IDX = LOG_INPUT'(NUM_ELEM - 1);

  rd_state_e              state_q, state_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [LOG_INPUT-1:0]   index_q, index_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   overflow_q, overflow_d;

  logic [1:0]             buf_full_s, buf_load_s, buf_rel_s;
  logic [FRAME_WIDTH-1:0] buf_data_s [2];
  logic                   handshake_s, final_beat_s, in_ready_s, capture_s, rd_other_s;
  logic [FRAME_WIDTH-1:0] src_frame_s;
  logic [LOG_INPUT-1:0]   elem_k_s;

  bitonic_frame_buf #(.FRAME_WIDTH(FRAME_WIDTH)) u_buf0 (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load_s[0]),
    .release_i (buf_rel_s[0]),
    .data_i    (in_data),
    .data_o    (buf_data_s[0]),
    .full_o    (buf_full_s[0])
  );

  bitonic_frame_buf #(.FRAME_WIDTH(FRAME_WIDTH)) u_buf1 (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load_s[1]),
    .release_i (buf_rel_s[1]),
    .data_i    (in_data),
    .data_o    (buf_data_s[1]),
    .full_o    (buf_full_s[1])
  );

  // The final beat frees its buffer in the same cycle, so it counts as space for a new frame.
  always_comb begin
    handshake_s  = out_valid_q & out_ready;
    final_beat_s = handshake_s & (index_q == LAST_IDX);
    in_ready_s   = ~buf_full_s[0] | ~buf_full_s[1] | final_beat_s;
    capture_s    = in_valid & in_ready_s;
    rd_other_s   = ~rd_sel_q;
    buf_load_s   = 2'b00;
    buf_load_s[wr_sel_q] = capture_s;
    buf_rel_s    = 2'b00;
    buf_rel_s[rd_sel_q]  = final_beat_s;
  end

  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    index_d    = index_q;
    wr_sel_d   = capture_s ? ~wr_sel_q : wr_sel_q;
    overflow_d = overflow_q | (in_valid & ~in_ready_s);
    case (state_q)
      IDLE: begin
        if (buf_full_s[rd_sel_q] | (capture_s & (wr_sel_q == rd_sel_q))) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (final_beat_s) begin
          rd_sel_d = rd_other_s;
          index_d  = {LOG_INPUT{1'b0}};
          if (buf_full_s[rd_other_s] | (capture_s & (wr_sel_q == rd_other_s))) begin
            state_d = STREAM;
          end else begin
            state_d = IDLE;
          end
        end else if (handshake_s) begin
          index_d = index_q + LOG_INPUT'(1'b1);
        end else begin
          index_d = index_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next state; a frame landing in the buffer about to be read
  // is taken straight from in_data so the first element appears one cycle after capture.
  always_comb begin
    if (capture_s & (wr_sel_q == rd_sel_d)) begin
      src_frame_s = in_data;
    end else begin
      src_frame_s = buf_data_s[rd_sel_d];
    end
`ifdef BITONIC_UNLOAD_REVERSE_EN
    elem_k_s = LAST_IDX - index_d;
`else
    elem_k_s = index_d;
`endif
    out_valid_d = (state_d == STREAM);
    if (out_valid_d) begin
      out_data_d = DATA_WIDTH'(elem_sel(FRAME_W_MAX'(src_frame_s), 32'(elem_k_s), DATA_WIDTH));
    end else begin
      out_data_d = {DATA_WIDTH{1'b0}};
    end
    out_last_d = out_valid_d & (index_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      index_q     <= {LOG_INPUT{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = index_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bitonic_unload_serializer.sv
// Scoreboard bench for bitonic_unload_serializer with DATA_WIDTH=4, LOG_INPUT=2 (N=4).
module tb_bitonic_unload_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_index;
  logic        out_last;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // {data, index, last}
  logic [6:0] exp_q [$];
  logic [6:0] exp_e;

  bitonic_unload_serializer #(.DATA_WIDTH(4), .LOG_INPUT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mk(input logic [3:0] e0, input logic [3:0] e1,
                                     input logic [3:0] e2, input logic [3:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic push_exp(input logic [15:0] f);
    logic [3:0] e;
    for (int k = 0; k < 4; k++) begin
`ifdef BITONIC_UNLOAD_REVERSE_EN
      e = f[(3-k)*4 +: 4];
`else
      e = f[k*4 +: 4];
`endif
      exp_q.push_back({e, 2'(k), (k == 3)});
    end
  endtask

  // Every accepted beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%0d index=%0d last=%0d, expected no beat",
                 out_data, out_index, out_last);
      end else begin
        exp_e = exp_q.pop_front();
        if ({out_data, out_index, out_last} !== exp_e) begin
          errors++;
          $display("FAIL stream_beat: got data=%0d index=%0d last=%0d, expected data=%0d index=%0d last=%0d",
                   out_data, out_index, out_last, exp_e[6:3], exp_e[2:1], exp_e[0]);
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_index, out_last, overflow, in_ready} !== {1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got valid=%0d data=%0d index=%0d last=%0d ovf=%0d in_ready=%0d, expected 0 0 0 0 0 1",
               out_valid, out_data, out_index, out_last, overflow, in_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] first_exp;
`ifdef BITONIC_UNLOAD_REVERSE_EN
    first_exp = 4'd9;
`else
    first_exp = 4'd1;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd1, 4'd3, 4'd5, 4'd9);
    push_exp(in_data);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_capture: got out_valid=%0d, expected 0", out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_index} !== {1'b1, first_exp, 2'd0}) begin
      errors++;
      $display("FAIL single_latency: got valid=%0d data=%0d index=%0d, expected 1 %0d 0",
               out_valid, out_data, out_index, first_exp);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got out_valid=%0d, expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    int hs;
    logic stalled;
    logic [3:0] prev_data;
    logic [1:0] prev_idx;
    hs = 0;
    stalled = 1'b0;
    prev_data = 4'd0;
    prev_idx = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd2, 4'd4, 4'd6, 4'd8);
    push_exp(in_data);
    out_ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = ((c % 3) == 0);
      @(negedge clk);
      if (stalled && out_valid) begin
        checks++;
        if ({out_data, out_index} !== {prev_data, prev_idx}) begin
          errors++;
          $display("FAIL stall_hold: got data=%0d index=%0d, expected data=%0d index=%0d",
                   out_data, out_index, prev_data, prev_idx);
        end
      end
      if (out_valid && out_ready) hs++;
      stalled = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx = out_index;
    end
    checks++;
    if (hs != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_handshakes: got %0d handshakes (%0d left), expected 4 (0 left)", hs, exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd1, 4'd2, 4'd3, 4'd4);
    push_exp(in_data);
    @(posedge clk); #1;
    in_data = mk(4'd5, 4'd6, 4'd7, 4'd8);
    push_exp(in_data);
    @(posedge clk); #1;
    in_data = mk(4'd9, 4'd10, 4'd11, 4'd12);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_in_ready: got in_ready=%0d, expected 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got overflow=%0d, expected 1", overflow);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain: got %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({overflow, out_valid} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_sticky: got overflow=%0d out_valid=%0d, expected 1 0", overflow, out_valid);
    end
  endtask

  task automatic test_final_beat_capture();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd3, 4'd1, 4'd4, 4'd1);
    push_exp(in_data);
    @(posedge clk); #1;
    in_data = mk(4'd5, 4'd9, 4'd2, 4'd6);
    push_exp(in_data);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_index} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL fb_full: got in_ready=%0d index=%0d, expected 0 0", in_ready, out_index);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd5, 4'd3, 4'd5, 4'd8);
    push_exp(in_data);
    @(negedge clk);
    checks++;
    if ({in_ready, out_index} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL fb_ready_on_last: got in_ready=%0d index=%0d, expected 1 3", in_ready, out_index);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({overflow, out_valid, out_index} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL fb_accept: got overflow=%0d valid=%0d index=%0d, expected 0 1 0",
               overflow, out_valid, out_index);
    end
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fb_drain: got %0d beats left overflow=%0d, expected 0 left overflow=0",
               exp_q.size(), overflow);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midstream();
    logic found;
    found = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd11, 4'd12, 4'd13, 4'd14);
    push_exp(in_data);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 2'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach_index2: got no beat at index 2, expected one within 20 cycles");
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_index, out_last, overflow, in_ready} !== {1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_values: got valid=%0d data=%0d index=%0d last=%0d ovf=%0d in_ready=%0d, expected 0 0 0 0 0 1",
               out_valid, out_data, out_index, out_last, overflow, in_ready);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd7, 4'd7, 4'd0, 4'd15);
    push_exp(in_data);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_index} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL mid_restart: got valid=%0d index=%0d, expected 1 0", out_valid, out_index);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_drain: got %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef BITONIC_UNLOAD_REVERSE_EN
  task automatic test_reverse();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = mk(4'd1, 4'd3, 4'd5, 4'd9);
    push_exp(in_data);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_index, out_last} !== {1'b1, 4'd9, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reverse_first: got valid=%0d data=%0d index=%0d last=%0d, expected 1 9 0 0",
               out_valid, out_data, out_index, out_last);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reverse_drain: got %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 16'h0000;
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    apply_reset();
    test_final_beat_capture();
    test_reset_midstream();
`ifdef BITONIC_UNLOAD_REVERSE_EN
    test_reverse();
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
